dm_lsu: RTL and testbench

//  Load/store initiator for the word-wide Data_mem port (CLK, A, WD, WE, RD).
//  - Accepts one byte/half/word request at a time from the CPU core.
//  - Drives the memory address/write port.
//  - Sub-word stores are done as read-modify-write.
//  - Load data is sign/zero-extended.
//  - Returns one response pulse per request.

---
 rtl/dm_lsu_pkg.sv | 23 ++
 rtl/dm_lsu_lane.sv | 43 ++++
 rtl/dm_lsu.sv | 136 +++++++++++++
 tb/tb_dm_lsu.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_lsu_pkg.sv
// Shared encodings and helpers for the Data_mem load/store unit.
package dm_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SIZE_H:  return lsb[0];
            SIZE_W:  return (lsb != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lsu_lane.sv
// Byte-lane steering: merges store data into a memory word and extracts/extends load data.
module dm_lsu_lane
    import dm_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lsb,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] load_val
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sign_fill;

    // Little-endian lanes: lsb selects the byte, lsb[1] selects the half.
    assign byte_v    = word[{lsb, 3'b000} +: 8];
    assign half_v    = word[{lsb[1], 4'b0000} +: 16];
    assign sign_fill = ~is_unsigned;

    // NOTE: every output gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        merged   = word;
        load_val = word;
        case (size)
            SIZE_B: begin
                merged[{lsb, 3'b000} +: 8] = wdata[7:0];
                load_val = {{24{sign_fill & byte_v[7]}}, byte_v};
            end
            SIZE_H: begin
                merged[{lsb[1], 4'b0000} +: 16] = wdata[15:0];
                load_val = {{16{sign_fill & half_v[15]}}, half_v};
            end
            default: begin
                merged   = wdata;
                load_val = word;
            end
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store initiator for a word-wide Data_mem port; sub-word stores use read-modify-write.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int DM_WORDS = 64,
    parameter int ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       WD,
    output logic              WE,
    input  logic [31:0]       RD
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DM_WORDS * 4);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic              err_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] a_q;
    logic              accept;
    logic              req_err;
    logic [31:0]       merged;
    logic [31:0]       load_val;

    assign accept  = req_valid && (state == IDLE);
    assign req_err = (req_size == 2'b11) || is_misaligned(req_size, req_addr[1:0])
                     || (req_addr >= ADDR_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                            state_nxt = RESP;
                    else if (req_we && req_size == SIZE_W)  state_nxt = WRITE;
                    else                                    state_nxt = READ;
                end
            end
            READ:    state_nxt = we_q ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // A only moves on an accepted, valid request so it holds its last value otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q  <= '0;
            size_q  <= SIZE_B;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            a_q     <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                wdata_q <= req_wdata;
                if (!req_err) begin
                    a_q <= {req_addr[ADDR_W-1:2], 2'b00};
                end
            end
            if (state == READ) begin
                word_q <= RD;
            end
        end
    end

    dm_lsu_lane u_lane (
        .word        (word_q),
        .wdata       (wdata_q),
        .size        (size_q),
        .lsb         (addr_q[1:0]),
        .is_unsigned (uns_q),
        .merged      (merged),
        .load_val    (load_val)
    );

    always_comb begin
        req_ready = 1'b0;
        WE        = 1'b0;
        WD        = '0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            IDLE:  req_ready = 1'b1;
            WRITE: begin
                WE = 1'b1;
                WD = merged;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && !we_q) begin
                    rsp_rdata = load_val;
                end
            end
            default: ;
        endcase
    end

    assign A = a_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu against a Data_mem model and a byte-level reference.
module tb_dm_lsu;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    int checks = 0;
    int errors = 0;

    // Data_mem model: combinational read, posedge write; bench preloads share the write port.
    logic [31:0] mem [64];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    // Reference model: memory as plain bytes.
    logic [7:0] ref_mem [256];

    dm_lsu #(.DM_WORDS(64), .ADDR_W(32)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .A            (A),
        .WD           (WD),
        .WE           (WE),
        .RD           (RD)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    assign RD = mem[A[7:2]];

    always @(posedge CLK) begin
        if (pre_we)  mem[pre_idx] <= pre_val;
        else if (WE) mem[A[7:2]] <= WD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge CLK);
        pre_we  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = v;
        for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = v[8*b +: 8];
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (addr >= 32'd256) || (size == 2'd1 && addr % 2 != 0)
               || (size == 2'd2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        int n = 1 << size;
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v |= 32'(ref_mem[addr + 32'(i)]) << (8*i);
        if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
        return v;
    endfunction

    // Issue one request from IDLE and observe it to its response (bounded).
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int we_cnt, output int we_lat, output logic [31:0] wd);
        @(negedge CLK);
        check("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        lat = 0; we_cnt = 0; we_lat = 0; wd = '0; rdata = 'x; err = 1'bx;
        while (lat < 8) begin
            @(negedge CLK);
            lat++;
            if (WE) begin we_cnt++; we_lat = lat; wd = WD; end
            if (rsp_valid) begin
                rdata = rsp_rdata;
                err   = rsp_err;
                check("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
                break;
            end
        end
    endtask

    // Run a request and check it against the reference; returns observed values for extra checks.
    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int we_lat, output logic [31:0] wd);
        logic e_err;
        logic [31:0] e_rdata;
        int e_lat;
        logic err;
        int lat, we_cnt;
        e_err   = ref_err(size, addr);
        e_rdata = (e_err || we) ? 32'd0 : ref_load(size, uns, addr);
        e_lat   = e_err ? 1 : (we && size != 2'd2) ? 3 : 2;
        do_req(we, size, uns, addr, wdata, rdata, err, lat, we_cnt, we_lat, wd);
        check({tag, "_err"}, {31'b0, err}, {31'b0, e_err});
        check({tag, "_rdata"}, rdata, e_rdata);
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_we_cycles"}, 32'(we_cnt), (we && !e_err) ? 32'd1 : 32'd0);
        if (we && !e_err) begin
            for (int i = 0; i < (1 << size); i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        end
    endtask

    logic [31:0] rd_o, wd_o;
    int          wl_o;
    logic [31:0] q_addr [4];
    logic [1:0]  q_size [4];
    logic        q_uns  [4];
    logic [31:0] q_exp  [4];
    int          acc, n_rsp;
    logic        will_acc;

    initial begin
        RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        #1;
        check("rst_A", A, 32'd0);
        check("rst_WD", WD, 32'd0);
        check("rst_WE", {31'b0, WE}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge CLK); @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // 1: word store then word load
        run("t1_sw", 1'b1, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF, rd_o, wl_o, wd_o);
        check("t1_wd", wd_o, 32'hFFFF_FFFF);
        check("t1_we_lat", 32'(wl_o), 32'd1);
        run("t1_lw", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd_o, wl_o, wd_o);
        check("t1_lw_const", rd_o, 32'hFFFF_FFFF);

        // 2: byte store read-modify-write
        preload(1, 32'h1122_3344);
        run("t2_sb", 1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00A5, rd_o, wl_o, wd_o);
        check("t2_wd", wd_o, 32'h1122_A544);
        check("t2_we_after_read", 32'(wl_o), 32'd2);

        // 3: sign/zero extension
        run("t3_lb_s", 1'b0, 2'd0, 1'b0, 32'h5, 32'h0, rd_o, wl_o, wd_o);
        check("t3_lb_s_const", rd_o, 32'hFFFF_FFA5);
        run("t3_lb_u", 1'b0, 2'd0, 1'b1, 32'h5, 32'h0, rd_o, wl_o, wd_o);
        check("t3_lb_u_const", rd_o, 32'h0000_00A5);
        run("t3_lh_s", 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, rd_o, wl_o, wd_o);
        check("t3_lh_s_const", rd_o, 32'h0000_1122);

        // 4: error cases
        run("t4_sh_mis", 1'b1, 2'd1, 1'b0, 32'h3, 32'hBEEF, rd_o, wl_o, wd_o);
        run("t4_lw_mis", 1'b0, 2'd2, 1'b0, 32'h2, 32'h0, rd_o, wl_o, wd_o);
        run("t4_lw_oor", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd_o, wl_o, wd_o);
        run("t4_illegal", 1'b0, 2'd3, 1'b0, 32'h8, 32'h0, rd_o, wl_o, wd_o);

        // 5: reset during the WRITE cycle of a byte store
        preload(1, 32'h1122_3344);
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h5; req_wdata = 32'hA5;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("t5_we_in_write", {31'b0, WE}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("t5_we_drop", {31'b0, WE}, 32'd0);
        check("t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
        @(posedge CLK); #1;
        check("t5_mem_kept", mem[1], 32'h1122_3344);
        @(negedge CLK);
        RST_N = 1'b1;
        check("t5_ready_after", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("t5_no_late_rsp", {31'b0, rsp_valid}, 32'd0);
        end

        // 6: four back-to-back loads with req_valid held high
        for (int i = 0; i < 4; i++) begin
            q_size[i] = 2'($urandom_range(0, 2));
            q_uns[i]  = 1'($urandom_range(0, 1));
            q_addr[i] = 32'($urandom_range(0, 63) * 4) + ((q_size[i] == 2'd0) ? 32'($urandom_range(0, 3)) :
                        (q_size[i] == 2'd1) ? 32'($urandom_range(0, 1) * 2) : 32'd0);
            q_exp[i]  = ref_load(q_size[i], q_uns[i], q_addr[i]);
        end
        acc = 0; n_rsp = 0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_size = q_size[0]; req_unsigned = q_uns[0];
        req_addr = q_addr[0];
        for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
            if (rsp_valid) begin
                check("t6_rdata", rsp_rdata, (n_rsp < 4) ? q_exp[n_rsp] : 32'hx);
                check("t6_ready_in_resp", {31'b0, req_ready}, 32'd0);
                n_rsp++;
            end
            will_acc = req_valid && req_ready;
            if (will_acc) check("t6_one_outstanding", 32'(acc), 32'(n_rsp));
            @(posedge CLK); #1;
            if (will_acc) begin
                acc++;
                if (acc < 4) begin
                    req_size = q_size[acc]; req_unsigned = q_uns[acc]; req_addr = q_addr[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge CLK);
        end
        req_valid = 1'b0;
        check("t6_accepts", 32'(acc), 32'd4);
        check("t6_responses", 32'(n_rsp), 32'd4);

        // Randomized mix against the byte-level reference
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 3) == 0)       ad = ad + 32'($urandom_range(0, 3));
            else if (sz == 2'd0)                 ad = ad + 32'($urandom_range(0, 3));
            else if (sz == 2'd1)                 ad = ad + 32'($urandom_range(0, 1) * 2);
            if ($urandom_range(0, 9) == 0)       ad = 32'd256 + 32'($urandom_range(0, 1000));
            run("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
                rd_o, wl_o, wd_o);
        end

        // Final sweep: DUT-written memory must equal the reference bytes
        for (int i = 0; i < 64; i++) begin
            check("final_mem", mem[i], {ref_mem[i*4+3], ref_mem[i*4+2], ref_mem[i*4+1], ref_mem[i*4]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
